// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if: request/response handshake bundle for the RV32I instruction encoder.
interface instruction_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  ctrl_code;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [7:0]  err_count;
    modport master (
        output in_valid, ctrl_code, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, instr, err, err_count
    );
    modport slave (
        input  in_valid, ctrl_code, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, instr, err, err_count
    );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder: two-stage RV32I assembler from internal operation codes to instruction words.
// Optional ENC_RANGE_CHECK_EN also rejects immediates that do not fit the target format.
module instruction_encoder (
    input logic                  clk,
    input logic                  rst_n,
    instruction_encoder_if.slave bus
);
    typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J} fmt_e;
    localparam logic [31:0] NOP = 32'h0000_0013;

    fmt_e        fmt_d, s1_fmt_q;
    logic [6:0]  op_d, f7_d, s1_op_q, s1_f7_q;
    logic [2:0]  f3_d, s1_f3_q;
    logic        illegal_d, rng_bad, s1_err_q, s1_valid_q, s2_valid_q, err_q;
    logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [31:0] s1_imm_q, instr_d, instr_q;
    logic [7:0]  err_count_q;
    logic        s1_adv, s2_adv;
    logic [5:0]  c;

    assign c = bus.ctrl_code;

    always_comb begin
        fmt_d     = F_I;
        op_d      = 7'b0010011;
        illegal_d = 1'b0;
        if (c <= 6'd9) begin
            fmt_d = F_R;
            op_d  = 7'b0110011;
        end else if (c <= 6'd15) fmt_d = F_I;
        else if (c <= 6'd18) fmt_d = F_SH;
        else if (c <= 6'd23) op_d = 7'b0000011;
        else if (c <= 6'd26) begin
            fmt_d = F_S;
            op_d  = 7'b0100011;
        end else if (c <= 6'd32) begin
            fmt_d = F_B;
            op_d  = 7'b1100011;
        end else if (c == 6'd33) begin
            fmt_d = F_U;
            op_d  = 7'b0110111;
        end else if (c == 6'd34) begin
            fmt_d = F_U;
            op_d  = 7'b0010111;
        end else if (c == 6'd35) begin
            fmt_d = F_J;
            op_d  = 7'b1101111;
        end else if (c == 6'd36) op_d = 7'b1100111;
        else illegal_d = 1'b1;
    end

    // funct3 grouped by value across all formats; unlisted codes use 000
    always_comb begin
        case (c)
            6'd2, 6'd16, 6'd20, 6'd25, 6'd28:         f3_d = 3'b001;
            6'd3, 6'd11, 6'd21, 6'd26:                f3_d = 3'b010;
            6'd4, 6'd12:                              f3_d = 3'b011;
            6'd5, 6'd13, 6'd22, 6'd29:                f3_d = 3'b100;
            6'd6, 6'd7, 6'd17, 6'd18, 6'd23, 6'd30:   f3_d = 3'b101;
            6'd8, 6'd14, 6'd31:                       f3_d = 3'b110;
            6'd9, 6'd15, 6'd32:                       f3_d = 3'b111;
            default:                                  f3_d = 3'b000;
        endcase
    end

    assign f7_d = (c == 6'd1 || c == 6'd7 || c == 6'd18) ? 7'b0100000 : 7'b0000000;

`ifdef ENC_RANGE_CHECK_EN
    logic sx12, sx13, sx21;
    assign sx12 = &bus.imm[31:11] | ~|bus.imm[31:11];
    assign sx13 = &bus.imm[31:12] | ~|bus.imm[31:12];
    assign sx21 = &bus.imm[31:20] | ~|bus.imm[31:20];
    assign rng_bad = (fmt_d == F_I || fmt_d == F_S) ? !sx12 :
                     (fmt_d == F_SH) ? |bus.imm[31:5] :
                     (fmt_d == F_B)  ? (!sx13 | bus.imm[0]) :
                     (fmt_d == F_J)  ? (!sx21 | bus.imm[0]) :
                     (fmt_d == F_U)  ? |bus.imm[11:0] : 1'b0;
`else
    assign rng_bad = 1'b0;
`endif

    always_comb begin
        instr_d = s1_err_q ? NOP :
            (s1_fmt_q == F_R)  ? {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q} :
            (s1_fmt_q == F_SH) ? {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q} :
            (s1_fmt_q == F_S)  ? {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q} :
            (s1_fmt_q == F_B)  ? {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                                  s1_imm_q[4:1], s1_imm_q[11], s1_op_q} :
            (s1_fmt_q == F_U)  ? {s1_imm_q[31:12], s1_rd_q, s1_op_q} :
            (s1_fmt_q == F_J)  ? {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                  s1_rd_q, s1_op_q} :
                                 {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
    end

    assign s2_adv = !s2_valid_q | bus.out_ready;
    assign s1_adv = !s1_valid_q | s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_fmt_q    <= F_I;
            s1_op_q     <= 7'd0;
            s1_f3_q     <= 3'd0;
            s1_f7_q     <= 7'd0;
            s1_err_q    <= 1'b0;
            s1_rd_q     <= 5'd0;
            s1_rs1_q    <= 5'd0;
            s1_rs2_q    <= 5'd0;
            s1_imm_q    <= 32'd0;
            instr_q     <= 32'd0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_fmt_q <= fmt_d;
                    s1_op_q  <= op_d;
                    s1_f3_q  <= f3_d;
                    s1_f7_q  <= f7_d;
                    s1_err_q <= illegal_d | rng_bad;
                    s1_rd_q  <= bus.rd;
                    s1_rs1_q <= bus.rs1;
                    s1_rs2_q <= bus.rs2;
                    s1_imm_q <= bus.imm;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    instr_q <= instr_d;
                    err_q   <= s1_err_q;
                end
            end
            if (s2_valid_q && bus.out_ready && err_q && err_count_q != 8'hFF)
                err_count_q <= err_count_q + 8'd1;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.instr     = instr_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed checks of encoding, latency, backpressure, errors and reset.
module tb_instruction_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          exp_cnt = 0;
    logic [32:0] q[$];

    instruction_encoder_if bus();
    instruction_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // record every delivered word; inputs only change just after rising edges
    always @(negedge clk)
        if (rst_n && bus.out_valid && bus.out_ready) q.push_back({bus.err, bus.instr});

    task automatic issue(input logic [5:0] code, input logic [4:0] d, s1, s2, input logic [31:0] im);
        bus.in_valid  = 1'b1;
        bus.ctrl_code = code;
        bus.rd        = d;
        bus.rs1       = s1;
        bus.rs2       = s2;
        bus.imm       = im;
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int i = 0; i < budget && q.size() < n; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.ctrl_code = 6'd0; bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.imm = 32'd0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.instr !== 32'd0 || bus.err !== 1'b0) begin
            bad++; $display("FAIL reset_out got v=%b i=%h e=%b want 0/0/0", bus.out_valid, bus.instr, bus.err);
        end
        total++;
        if (bus.err_count !== 8'd0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_cnt_rdy got cnt=%0d rdy=%b want 0/1", bus.err_count, bus.in_ready);
        end
    endtask

    task automatic test_add_latency();
        q.delete();
        issue(6'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL add_early got out_valid=%b want 0", bus.out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b1 || bus.instr !== 32'h002081B3 || bus.err !== 1'b0) begin
            bad++; $display("FAIL add got v=%b i=%h e=%b want 1/002081b3/0", bus.out_valid, bus.instr, bus.err);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || q.size() != 1) begin
            bad++; $display("FAIL add_drain got v=%b n=%0d want 0/1", bus.out_valid, q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp [5];
        exp = '{{1'b0, 32'h40335293}, {1'b0, 32'h00208463}, {1'b0, 32'h001000EF},
                {1'b0, 32'h0020A623}, {1'b0, 32'h123452B7}};
        q.delete();
        issue(6'd18, 5'd5, 5'd6, 5'd0, 32'd3);           @(posedge clk); #1;
        issue(6'd27, 5'd0, 5'd1, 5'd2, 32'd8);           @(posedge clk); #1;
        issue(6'd35, 5'd1, 5'd0, 5'd0, 32'd2048);        @(posedge clk); #1;
        issue(6'd26, 5'd0, 5'd1, 5'd2, 32'd12);          @(posedge clk); #1;
        issue(6'd33, 5'd5, 5'd0, 5'd0, 32'h12345000);    @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(5, 20);
        total++;
        if (q.size() != 5) begin
            bad++; $display("FAIL b2b_count got %0d want 5", q.size());
        end
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            total++;
            if (q[i] !== exp[i]) begin
                bad++; $display("FAIL b2b[%0d] got %h want %h", i, q[i], exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        q.delete();
        issue(6'd40, 5'd7, 5'd7, 5'd7, 32'h1234);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_cnt++;
        wait_out(1, 10);
        total++;
        if (q.size() != 1 || q[0] !== {1'b1, 32'h00000013}) begin
            bad++; $display("FAIL illegal got n=%0d w=%h want 1/100000013", q.size(), (q.size() > 0) ? q[0] : 33'h0);
        end
        total++;
        if (bus.err_count !== 8'(exp_cnt)) begin
            bad++; $display("FAIL illegal_cnt got %0d want %0d", bus.err_count, exp_cnt);
        end
    endtask

    task automatic test_range();
        logic [32:0] exp0;
`ifdef ENC_RANGE_CHECK_EN
        exp0 = {1'b1, 32'h00000013};
        exp_cnt++;
`else
        exp0 = {1'b0, 32'h80000093};
`endif
        q.delete();
        issue(6'd10, 5'd1, 5'd0, 5'd0, 32'h00000800);  @(posedge clk); #1;
        issue(6'd10, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);  @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(2, 10);
        total++;
        if (q.size() != 2 || q[0] !== exp0) begin
            bad++; $display("FAIL addi_800 got n=%0d w=%h want %h", q.size(), (q.size() > 0) ? q[0] : 33'h0, exp0);
        end
        total++;
        if (q.size() != 2 || q[1] !== {1'b0, 32'hFFF00093}) begin
            bad++; $display("FAIL addi_m1 got n=%0d w=%h want 0fff00093", q.size(), (q.size() > 1) ? q[1] : 33'h0);
        end
        total++;
        if (bus.err_count !== 8'(exp_cnt)) begin
            bad++; $display("FAIL range_cnt got %0d want %0d", bus.err_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp [3];
        exp = '{{1'b0, 32'h002081B3}, {1'b0, 32'h402081B3}, {1'b0, 32'h0020C233}};
        q.delete();
        bus.out_ready = 1'b0;
        issue(6'd0, 5'd3, 5'd1, 5'd2, 32'd0);  @(posedge clk); #1;
        issue(6'd1, 5'd3, 5'd1, 5'd2, 32'd0);  @(posedge clk); #1;
        issue(6'd5, 5'd4, 5'd1, 5'd2, 32'd0);
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.instr !== 32'h002081B3) begin
            bad++; $display("FAIL bp_full got rdy=%b v=%b i=%h want 0/1/002081b3", bus.in_ready, bus.out_valid, bus.instr);
        end
        @(posedge clk); #1;
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.instr !== 32'h002081B3 || q.size() != 0) begin
            bad++; $display("FAIL bp_hold got rdy=%b v=%b i=%h n=%0d want 0/1/002081b3/0",
                            bus.in_ready, bus.out_valid, bus.instr, q.size());
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(3, 20);
        total++;
        if (q.size() != 3) begin
            bad++; $display("FAIL bp_count got %0d want 3", q.size());
        end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            total++;
            if (q[i] !== exp[i]) begin
                bad++; $display("FAIL bp_order[%0d] got %h want %h", i, q[i], exp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        q.delete();
        issue(6'd40, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (300) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_cnt = (exp_cnt + 300 > 255) ? 255 : exp_cnt + 300;
        wait_out(300, 400);
        total++;
        if (q.size() != 300) begin
            bad++; $display("FAIL sat_count got %0d want 300", q.size());
        end
        total++;
        if (bus.err_count !== 8'(exp_cnt)) begin
            bad++; $display("FAIL sat_cnt got %0d want %0d", bus.err_count, exp_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        q.delete();
        bus.out_ready = 1'b0;
        issue(6'd0, 5'd3, 5'd1, 5'd2, 32'd0);  @(posedge clk); #1;
        issue(6'd1, 5'd3, 5'd1, 5'd2, 32'd0);  @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.err_count !== 8'd0) begin
            bad++; $display("FAIL rst_mid got v=%b cnt=%0d want 0/0", bus.out_valid, bus.err_count);
        end
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_stale got n=%0d v=%b want 0/0", q.size(), bus.out_valid);
        end
        issue(6'd0, 5'd3, 5'd1, 5'd2, 32'd0);  @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(1, 10);
        total++;
        if (q.size() != 1 || q[0] !== {1'b0, 32'h002081B3}) begin
            bad++; $display("FAIL rst_after got n=%0d w=%h want 1/0002081b3", q.size(), (q.size() > 0) ? q[0] : 33'h0);
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_illegal();
        test_range();
        test_backpressure();
        test_saturation();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
